mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of an in-order pipeline. It takes the EX/MEM register
// contents, runs at most one load or store on a simple ready-based RAM port,
// and presents the results to the MEM/WB register.
//
// Parameters
//   ALIGN_CHECK   1 = flag misaligned half/word accesses, 0 = never flag
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   stall_current_stage         pipeline controller holds this stage
//   flush                       discard the in-flight instruction
//   mem_read_flag_in            load request
//   mem_write_flag_in           store request
//   mem_sign_ext_flag_in        load sign extension (passed through)
//   mem_sel_in[3:0]             access size: 0001 byte, 0011 half, 1111 word
//   mem_write_data_in[31:0]     store data, right-aligned
//   result_in[31:0]             ALU result / effective address
//   reg_write_en_in             register write enable (passed through)
//   reg_write_addr_in[4:0]      destination register (passed through)
//   current_pc_addr_in[31:0]    PC of the instruction (passed through)
//   ram_en                      RAM request strobe
//   ram_write_en[3:0]           RAM byte write strobes
//   ram_addr[31:0]              word-aligned RAM address
//   ram_write_data[31:0]        lane-aligned store data
//   ram_ready                   RAM completes the current request
//   ram_read_data[31:0]         RAM read data, valid with ram_ready
//   stall_request               this stage needs the pipeline frozen
//   address_error               misaligned access, to the exception unit
//   *_out                       MEM/WB register inputs
//   ram_read_data_out[31:0]     captured load word (0 outside DONE)
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_current_stage,
  input  logic        flush,

  input  logic        mem_read_flag_in,
  input  logic        mem_write_flag_in,
  input  logic        mem_sign_ext_flag_in,
  input  logic [3:0]  mem_sel_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] current_pc_addr_in,

  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic        ram_ready,
  input  logic [31:0] ram_read_data,

  output logic        stall_request,
  output logic        address_error,

  output logic        mem_read_flag_out,
  output logic        mem_write_flag_out,
  output logic        mem_sign_ext_flag_out,
  output logic [3:0]  mem_sel_out,
  output logic [31:0] result_out,
  output logic        reg_write_en_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] current_pc_addr_out,
  output logic [31:0] ram_read_data_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_DROP = 2'd3
  } state_t;

  // Half needs an even address, word needs a 4-byte aligned address.
  // Any other select pattern (byte, or unused codes) is never misaligned.
  function automatic logic is_misaligned(input logic [3:0] sel,
                                         input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    if (sel == 4'b0011) begin
      bad = offset[0];
    end else if (sel == 4'b1111) begin
      bad = (offset != 2'b00);
    end
    return bad;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] buf_q, buf_d;

  // Request registers: the RAM outputs are frozen from these once a
  // transaction outlives its launch cycle, so the bus stays stable in WAIT
  // and DROP regardless of what the upstream register does meanwhile.
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_be_q, req_be_d;

  logic        rw_flag;
  logic        access;
  logic [1:0]  offset;
  logic [3:0]  lane_mask;
  logic [31:0] launch_addr;
  logic [31:0] launch_wdata;
  logic [3:0]  launch_be;

  // -------------------------------------------------------------------------
  // Address decode and lane alignment
  // -------------------------------------------------------------------------
  always_comb begin
    rw_flag       = mem_read_flag_in | mem_write_flag_in;
    offset        = result_in[1:0];
    lane_mask     = mem_sel_in << offset;
    address_error = ALIGN_CHECK && rw_flag && is_misaligned(mem_sel_in, offset);
    access        = rw_flag & ~address_error & ~flush;
    launch_addr   = {result_in[31:2], 2'b00};
    launch_wdata  = mem_write_data_in << {offset, 3'b000};
    launch_be     = mem_write_flag_in ? lane_mask : 4'b0000;
  end

  // -------------------------------------------------------------------------
  // Pass-through to MEM/WB; a faulting or flushed instruction must not
  // write the register file.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_read_flag_out     = mem_read_flag_in;
    mem_write_flag_out    = mem_write_flag_in;
    mem_sign_ext_flag_out = mem_sign_ext_flag_in;
    mem_sel_out           = lane_mask;
    result_out            = result_in;
    reg_write_en_out      = reg_write_en_in & ~address_error & ~flush;
    reg_write_addr_out    = reg_write_addr_in;
    current_pc_addr_out   = current_pc_addr_in;
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  always_ff @(posedge clk) begin
    req_addr_q  <= req_addr_d;
    req_wdata_q <= req_wdata_d;
    req_be_q    <= req_be_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;

    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          req_addr_d  = launch_addr;
          req_wdata_d = launch_wdata;
          req_be_d    = launch_be;
          if (ram_ready) begin
            buf_d   = ram_read_data;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (ram_ready) begin
          // A flush landing on the completing cycle still finishes the bus
          // transfer, but the instruction is gone so the data is dropped.
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            buf_d   = ram_read_data;
            state_d = S_DONE;
          end
        end else if (flush) begin
          state_d = S_DROP;
        end
      end

      S_DROP: begin
        if (ram_ready) begin
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        if (!stall_current_stage || flush) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    ram_en            = 1'b0;
    ram_write_en      = 4'b0000;
    ram_addr          = req_addr_q;
    ram_write_data    = req_wdata_q;
    stall_request     = 1'b0;
    ram_read_data_out = 32'h0;

    unique case (state_q)
      S_IDLE: begin
        // Launch cycle drives straight from the inputs.
        ram_en         = access;
        ram_addr       = launch_addr;
        ram_write_data = launch_wdata;
        ram_write_en   = access ? launch_be : 4'b0000;
        stall_request  = access;
      end

      S_WAIT, S_DROP: begin
        ram_en        = 1'b1;
        ram_write_en  = req_be_q;
        stall_request = 1'b1;
      end

      S_DONE: begin
        ram_read_data_out = buf_q;
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        stall_current_stage;
  logic        flush;
  logic        mem_read_flag_in;
  logic        mem_write_flag_in;
  logic        mem_sign_ext_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in;
  logic [31:0] result_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic [31:0] current_pc_addr_in;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_ready;
  logic [31:0] ram_read_data;
  logic        stall_request;
  logic        address_error;
  logic        mem_read_flag_out;
  logic        mem_write_flag_out;
  logic        mem_sign_ext_flag_out;
  logic [3:0]  mem_sel_out;
  logic [31:0] result_out;
  logic        reg_write_en_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] current_pc_addr_out;
  logic [31:0] ram_read_data_out;

  int checks;
  int errors;

  mem_stage #(.ALIGN_CHECK(1'b1)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .stall_current_stage   (stall_current_stage),
    .flush                 (flush),
    .mem_read_flag_in      (mem_read_flag_in),
    .mem_write_flag_in     (mem_write_flag_in),
    .mem_sign_ext_flag_in  (mem_sign_ext_flag_in),
    .mem_sel_in            (mem_sel_in),
    .mem_write_data_in     (mem_write_data_in),
    .result_in             (result_in),
    .reg_write_en_in       (reg_write_en_in),
    .reg_write_addr_in     (reg_write_addr_in),
    .current_pc_addr_in    (current_pc_addr_in),
    .ram_en                (ram_en),
    .ram_write_en          (ram_write_en),
    .ram_addr              (ram_addr),
    .ram_write_data        (ram_write_data),
    .ram_ready             (ram_ready),
    .ram_read_data         (ram_read_data),
    .stall_request         (stall_request),
    .address_error         (address_error),
    .mem_read_flag_out     (mem_read_flag_out),
    .mem_write_flag_out    (mem_write_flag_out),
    .mem_sign_ext_flag_out (mem_sign_ext_flag_out),
    .mem_sel_out           (mem_sel_out),
    .result_out            (result_out),
    .reg_write_en_out      (reg_write_en_out),
    .reg_write_addr_out    (reg_write_addr_out),
    .current_pc_addr_out   (current_pc_addr_out),
    .ram_read_data_out     (ram_read_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    stall_current_stage  = 1'b0;
    flush                = 1'b0;
    mem_read_flag_in     = 1'b0;
    mem_write_flag_in    = 1'b0;
    mem_sign_ext_flag_in = 1'b0;
    mem_sel_in           = 4'b0000;
    mem_write_data_in    = 32'h0;
    result_in            = 32'h0;
    reg_write_en_in      = 1'b0;
    reg_write_addr_in    = 5'd0;
    current_pc_addr_in   = 32'h0;
    ram_ready            = 1'b0;
    ram_read_data        = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
    checks++; if (stall_request !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_request); end
    checks++; if (ram_read_data_out !== 32'h0) begin errors++; $display("FAIL reset_rdata_out: got %h want 00000000", ram_read_data_out); end
    checks++; if (address_error !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b want 0", address_error); end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    clear_inputs();
    result_in = 32'h12345678; current_pc_addr_in = 32'h00000080;
    reg_write_en_in = 1'b1; reg_write_addr_in = 5'd17;
    mem_sign_ext_flag_in = 1'b1; mem_sel_in = 4'b0011;
    #1;
    checks++; if (result_out !== 32'h12345678) begin errors++; $display("FAIL pt_result: got %h want 12345678", result_out); end
    checks++; if (current_pc_addr_out !== 32'h80) begin errors++; $display("FAIL pt_pc: got %h want 00000080", current_pc_addr_out); end
    checks++; if (reg_write_addr_out !== 5'd17) begin errors++; $display("FAIL pt_waddr: got %0d want 17", reg_write_addr_out); end
    checks++; if (reg_write_en_out !== 1'b1 || mem_sign_ext_flag_out !== 1'b1) begin errors++; $display("FAIL pt_flags: got we=%b sx=%b want 1 1", reg_write_en_out, mem_sign_ext_flag_out); end
    // 0011 << 0 (offset of 0x...78 is 0)
    checks++; if (mem_sel_out !== 4'b0011) begin errors++; $display("FAIL pt_sel0: got %b want 0011", mem_sel_out); end
    // no access flag, so an odd address is not an error
    result_in = 32'h0000000A;
    #1;
    checks++; if (mem_sel_out !== 4'b1100 || address_error !== 1'b0) begin errors++; $display("FAIL pt_sel2: got sel=%b err=%b want 1100 0", mem_sel_out, address_error); end
    flush = 1'b1; mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h40;
    #1;
    checks++; if (reg_write_en_out !== 1'b0) begin errors++; $display("FAIL pt_flush_we: got %b want 0", reg_write_en_out); end
    checks++; if (ram_en !== 1'b0 || stall_request !== 1'b0) begin errors++; $display("FAIL pt_flush_access: got en=%b stall=%b want 0 0", ram_en, stall_request); end
    checks++; if (mem_read_flag_out !== 1'b1) begin errors++; $display("FAIL pt_rd_flag: got %b want 1", mem_read_flag_out); end
    clear_inputs();
  endtask

  task automatic test_word_load();
    @(negedge clk);
    clear_inputs();
    mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h100;
    reg_write_en_in = 1'b1; reg_write_addr_in = 5'd5;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin ram_ready = 1'b1; ram_read_data = 32'hDEADBEEF; end
      #1;
      checks++; if (stall_request !== 1'b1) begin errors++; $display("FAIL wl_stall_c%0d: got %b want 1", c, stall_request); end
      checks++; if (ram_en !== 1'b1 || ram_addr !== 32'h100 || ram_write_en !== 4'b0000) begin errors++; $display("FAIL wl_bus_c%0d: got en=%b addr=%h we=%b want 1 00000100 0000", c, ram_en, ram_addr, ram_write_en); end
      checks++; if (ram_read_data_out !== 32'h0) begin errors++; $display("FAIL wl_rdata_early_c%0d: got %h want 00000000", c, ram_read_data_out); end
      @(negedge clk);
    end
    ram_ready = 1'b0; ram_read_data = 32'h0;
    #1;
    checks++; if (stall_request !== 1'b0) begin errors++; $display("FAIL wl_done_stall: got %b want 0", stall_request); end
    checks++; if (ram_read_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_done_rdata: got %h want deadbeef", ram_read_data_out); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL wl_done_en: got %b want 0", ram_en); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ram_read_data_out !== 32'h0 || stall_request !== 1'b0) begin errors++; $display("FAIL wl_idle: got rdata=%h stall=%b want 00000000 0", ram_read_data_out, stall_request); end
  endtask

  task automatic test_stores();
    // byte store to 0x203, immediate ready
    @(negedge clk);
    clear_inputs();
    mem_write_flag_in = 1'b1; mem_sel_in = 4'b0001; result_in = 32'h203;
    mem_write_data_in = 32'h000000AB; ram_ready = 1'b1;
    #1;
    checks++; if (ram_addr !== 32'h200) begin errors++; $display("FAIL sb_addr: got %h want 00000200", ram_addr); end
    checks++; if (ram_write_en !== 4'b1000 || ram_en !== 1'b1) begin errors++; $display("FAIL sb_we: got we=%b en=%b want 1000 1", ram_write_en, ram_en); end
    checks++; if (ram_write_data !== 32'hAB000000) begin errors++; $display("FAIL sb_wdata: got %h want ab000000", ram_write_data); end
    checks++; if (mem_sel_out !== 4'b1000) begin errors++; $display("FAIL sb_sel: got %b want 1000", mem_sel_out); end
    @(negedge clk);
    ram_ready = 1'b0;
    #1;
    checks++; if (ram_en !== 1'b0 || ram_write_en !== 4'b0000 || stall_request !== 1'b0) begin errors++; $display("FAIL sb_done: got en=%b we=%b stall=%b want 0 0000 0", ram_en, ram_write_en, stall_request); end
    // half store to 0x22 with wait state; upstream wobbles while waiting
    @(negedge clk);
    clear_inputs();
    mem_write_flag_in = 1'b1; mem_sel_in = 4'b0011; result_in = 32'h22;
    mem_write_data_in = 32'h00001234;
    #1;
    checks++; if (ram_addr !== 32'h20 || ram_write_en !== 4'b1100 || ram_write_data !== 32'h12340000) begin errors++; $display("FAIL sh_launch: got addr=%h we=%b wd=%h want 00000020 1100 12340000", ram_addr, ram_write_en, ram_write_data); end
    @(negedge clk);
    result_in = 32'h5554; mem_write_data_in = 32'h0000FFFF;
    #1;
    checks++; if (ram_addr !== 32'h20 || ram_write_en !== 4'b1100 || ram_write_data !== 32'h12340000 || ram_en !== 1'b1) begin errors++; $display("FAIL sh_hold: got en=%b addr=%h we=%b wd=%h want 1 00000020 1100 12340000", ram_en, ram_addr, ram_write_en, ram_write_data); end
    ram_ready = 1'b1;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ram_en !== 1'b0 || stall_request !== 1'b0) begin errors++; $display("FAIL sh_done: got en=%b stall=%b want 0 0", ram_en, stall_request); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    clear_inputs();
    mem_read_flag_in = 1'b1; mem_sel_in = 4'b0011; result_in = 32'h101; reg_write_en_in = 1'b1;
    #1;
    checks++; if (address_error !== 1'b1) begin errors++; $display("FAIL mis_half_err: got %b want 1", address_error); end
    checks++; if (ram_en !== 1'b0 || stall_request !== 1'b0) begin errors++; $display("FAIL mis_half_bus: got en=%b stall=%b want 0 0", ram_en, stall_request); end
    checks++; if (reg_write_en_out !== 1'b0) begin errors++; $display("FAIL mis_half_we: got %b want 0", reg_write_en_out); end
    @(negedge clk);
    mem_read_flag_in = 1'b0; mem_write_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h102;
    #1;
    checks++; if (address_error !== 1'b1 || ram_en !== 1'b0) begin errors++; $display("FAIL mis_word: got err=%b en=%b want 1 0", address_error, ram_en); end
    mem_write_flag_in = 1'b0;
    #1;
    checks++; if (address_error !== 1'b0) begin errors++; $display("FAIL mis_noflag: got %b want 0", address_error); end
    mem_read_flag_in = 1'b1; mem_sel_in = 4'b0001; result_in = 32'h103;
    #1;
    checks++; if (address_error !== 1'b0 || ram_en !== 1'b1) begin errors++; $display("FAIL mis_byte_ok: got err=%b en=%b want 0 1", address_error, ram_en); end
    clear_inputs();
  endtask

  task automatic test_flush_wait();
    @(negedge clk);
    clear_inputs();
    mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h300; reg_write_en_in = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (stall_request !== 1'b1 || ram_en !== 1'b1 || reg_write_en_out !== 1'b0) begin errors++; $display("FAIL fw_flush: got stall=%b en=%b we=%b want 1 1 0", stall_request, ram_en, reg_write_en_out); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ram_en !== 1'b1 || stall_request !== 1'b1 || ram_addr !== 32'h300) begin errors++; $display("FAIL fw_drop1: got en=%b stall=%b addr=%h want 1 1 00000300", ram_en, stall_request, ram_addr); end
    checks++; if (ram_read_data_out !== 32'h0) begin errors++; $display("FAIL fw_drop1_rdata: got %h want 00000000", ram_read_data_out); end
    @(negedge clk);
    ram_ready = 1'b1; ram_read_data = 32'h12345678;
    #1;
    checks++; if (ram_en !== 1'b1 || ram_read_data_out !== 32'h0) begin errors++; $display("FAIL fw_drop2: got en=%b rdata=%h want 1 00000000", ram_en, ram_read_data_out); end
    @(negedge clk);
    ram_ready = 1'b0; ram_read_data = 32'h0;
    #1;
    checks++; if (ram_en !== 1'b0 || stall_request !== 1'b0 || ram_read_data_out !== 32'h0) begin errors++; $display("FAIL fw_idle: got en=%b stall=%b rdata=%h want 0 0 00000000", ram_en, stall_request, ram_read_data_out); end
  endtask

  task automatic test_flush_ready_wait();
    @(negedge clk);
    clear_inputs();
    mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h310;
    @(negedge clk);
    flush = 1'b1; ram_ready = 1'b1; ram_read_data = 32'h99999999;
    #1;
    checks++; if (stall_request !== 1'b1) begin errors++; $display("FAIL frw_wait: got stall=%b want 1", stall_request); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ram_read_data_out !== 32'h0 || stall_request !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("FAIL frw_idle: got rdata=%h stall=%b en=%b want 00000000 0 0", ram_read_data_out, stall_request, ram_en); end
  endtask

  task automatic test_done_hold();
    @(negedge clk);
    clear_inputs();
    mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h400;
    ram_ready = 1'b1; ram_read_data = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      stall_current_stage = 1'b1; ram_ready = 1'b0; ram_read_data = 32'h55555555;
      #1;
      checks++; if (ram_read_data_out !== 32'hCAFEF00D || ram_en !== 1'b0 || stall_request !== 1'b0) begin errors++; $display("FAIL dh_hold_c%0d: got rdata=%h en=%b stall=%b want cafef00d 0 0", c, ram_read_data_out, ram_en, stall_request); end
    end
    @(negedge clk);
    stall_current_stage = 1'b0;
    #1;
    checks++; if (ram_read_data_out !== 32'hCAFEF00D) begin errors++; $display("FAIL dh_release: got %h want cafef00d", ram_read_data_out); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ram_read_data_out !== 32'h0 || ram_en !== 1'b0) begin errors++; $display("FAIL dh_idle: got rdata=%h en=%b want 00000000 0", ram_read_data_out, ram_en); end
    // flush while held in DONE leaves immediately
    mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h404;
    ram_ready = 1'b1; ram_read_data = 32'hA5A5A5A5;
    @(negedge clk);
    ram_ready = 1'b0; stall_current_stage = 1'b1; flush = 1'b1;
    #1;
    checks++; if (ram_read_data_out !== 32'hA5A5A5A5) begin errors++; $display("FAIL dh_flush_done: got %h want a5a5a5a5", ram_read_data_out); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ram_read_data_out !== 32'h0) begin errors++; $display("FAIL dh_flush_idle: got %h want 00000000", ram_read_data_out); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    clear_inputs();
    mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h10;
    ram_ready = 1'b1; ram_read_data = 32'h11111111;
    @(negedge clk);
    ram_ready = 1'b0;
    #1;
    checks++; if (ram_read_data_out !== 32'h11111111) begin errors++; $display("FAIL b2b_first: got %h want 11111111", ram_read_data_out); end
    @(negedge clk);
    result_in = 32'h14; ram_ready = 1'b1; ram_read_data = 32'h22222222;
    #1;
    checks++; if (ram_en !== 1'b1 || ram_addr !== 32'h14 || ram_read_data_out !== 32'h0) begin errors++; $display("FAIL b2b_launch: got en=%b addr=%h rdata=%h want 1 00000014 00000000", ram_en, ram_addr, ram_read_data_out); end
    @(negedge clk);
    ram_ready = 1'b0;
    #1;
    checks++; if (ram_read_data_out !== 32'h22222222) begin errors++; $display("FAIL b2b_second: got %h want 22222222", ram_read_data_out); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    clear_inputs();
    mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h500;
    @(negedge clk);
    #1;
    checks++; if (stall_request !== 1'b1 || ram_en !== 1'b1) begin errors++; $display("FAIL rw_wait: got stall=%b en=%b want 1 1", stall_request, ram_en); end
    rst = 1'b1; mem_read_flag_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ram_en !== 1'b0 || stall_request !== 1'b0 || ram_read_data_out !== 32'h0) begin errors++; $display("FAIL rw_after: got en=%b stall=%b rdata=%h want 0 0 00000000", ram_en, stall_request, ram_read_data_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_passthrough();
    test_word_load();
    test_stores();
    test_misaligned();
    test_flush_wait();
    test_flush_ready_wait();
    test_done_hold();
    test_back_to_back();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
